// File: rtl/interconnect_sched_pkg.sv
// interconnect_sched_pkg
// Shared types and constants for the interconnect scheduler slice.
//   sched_state_e : scheduler FSM states (idle, mux switch, mux settle, dwell)
//   MUX_LATENCY   : register stages in the shared mux (sel_reg, then out)
//   SETTLE_CYCLES : cycles spent in SETTLE so data_valid lines up with mux out
package interconnect_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSwitch,
        StSettle,
        StDwell
    } sched_state_e;

    localparam int unsigned MUX_LATENCY   = 2;
    localparam int unsigned SETTLE_CYCLES = MUX_LATENCY - 1;

endpackage

// File: rtl/interconnect_scheduler_rr_pick.sv
// rr_pick
// Combinational round-robin winner search. The search begins at last+1
// (mod N_INPUTS) and wraps, so the most recently granted index has the
// lowest priority.
// Ports:
//   req  : per-channel request vector
//   last : index of the most recent grant
//   any  : at least one request is set
//   idx  : winning index (0 when any is low)
module rr_pick #(
    parameter int unsigned N_INPUTS  = 3,
    parameter int unsigned SEL_WIDTH = 2
) (
    input  logic [N_INPUTS-1:0]  req,
    input  logic [SEL_WIDTH-1:0] last,
    output logic                 any,
    output logic [SEL_WIDTH-1:0] idx
);

    int                   pos;
    logic [SEL_WIDTH-1:0] pos_idx;

    // Walk offsets from farthest to nearest so the nearest hit after last
    // is the one that sticks.
    always_comb begin
        any     = 1'b0;
        idx     = '0;
        pos     = 0;
        pos_idx = '0;
        for (int off = N_INPUTS; off >= 1; off--) begin
            pos = int'(last) + off;
            if (pos >= int'(N_INPUTS)) begin
                pos = pos - int'(N_INPUTS);
            end
            pos_idx = SEL_WIDTH'(pos);
            if (req[pos_idx]) begin
                any = 1'b1;
                idx = pos_idx;
            end
        end
    end

endmodule

// File: rtl/interconnect_scheduler.sv
// interconnect_scheduler
// Round-robin scheduler for the shared simple_interconnect N-to-1 mux. It
// picks a requester, loads the mux select with a one-cycle clken strobe,
// waits out the mux pipeline, then holds the grant for a dwell period.
// Ports:
//   clk, resetn : clock and synchronous active-low reset
//   req         : per-channel level request
//   dwell       : grant length in valid cycles (0 behaves as 1)
//   lock        : (INTERCONNECT_SCHED_LOCK_EN only) extend the grant past dwell
//   sel, clken  : to the mux select and load-enable pins
//   grant       : one-hot current grant, zero when idle
//   data_valid  : mux out currently carries the granted channel
//   busy        : scheduler is not idle
// Optional feature macro: INTERCONNECT_SCHED_LOCK_EN
module interconnect_scheduler
    import interconnect_sched_pkg::*;
#(
    parameter int unsigned N_INPUTS    = 3,
    parameter int unsigned SEL_WIDTH   = 2,
    parameter int unsigned DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [N_INPUTS-1:0]    req,
    input  logic [DWELL_WIDTH-1:0] dwell,
`ifdef INTERCONNECT_SCHED_LOCK_EN
    input  logic                   lock,
`endif
    output logic [SEL_WIDTH-1:0]   sel,
    output logic                   clken,
    output logic [N_INPUTS-1:0]    grant,
    output logic                   data_valid,
    output logic                   busy
);

    sched_state_e           state_q, state_d;
    logic [SEL_WIDTH-1:0]   k_q, k_d;
    logic [SEL_WIDTH-1:0]   last_q, last_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]             settle_q, settle_d;

    logic                   pick_any;
    logic [SEL_WIDTH-1:0]   pick_idx;
    logic                   req_k;
    logic                   lock_hold;
    logic                   cnt_is_one;
    logic [DWELL_WIDTH-1:0] dwell_eff;

    rr_pick #(
        .N_INPUTS  (N_INPUTS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_rr_pick (
        .req  (req),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign req_k      = req[k_q];
    assign cnt_is_one = (cnt_q == DWELL_WIDTH'(1));
    assign dwell_eff  = (dwell == '0) ? DWELL_WIDTH'(1) : dwell;

`ifdef INTERCONNECT_SCHED_LOCK_EN
    assign lock_hold = lock & req_k;
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    k_d     = pick_idx;
                    state_d = StSwitch;
                end
            end
            StSwitch: begin
                cnt_d    = dwell_eff;
                last_d   = k_q;
                settle_d = '0;
                state_d  = StSettle;
            end
            StSettle: begin
                if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
                    state_d = StDwell;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            StDwell: begin
                // A dropped request ends the grant at once; expiry only
                // counts when lock is not holding the grant open.
                if (!req_k || (cnt_is_one && !lock_hold)) begin
                    if (pick_any) begin
                        k_d     = pick_idx;
                        state_d = StSwitch;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (!cnt_is_one) begin
                    cnt_d = cnt_q - DWELL_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // k_q only changes on entry to SWITCH, so sel holds everywhere else.
    always_comb begin
        sel        = k_q;
        clken      = (state_q == StSwitch);
        busy       = (state_q != StIdle);
        data_valid = (state_q == StDwell) && req_k;
        grant      = '0;
        if (state_q != StIdle) begin
            grant[k_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            k_q      <= '0;
            last_q   <= SEL_WIDTH'(N_INPUTS - 1);
            cnt_q    <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
        end
    end

endmodule

// File: tb/tb_interconnect_scheduler.sv
// tb_interconnect_scheduler
// Randomized and directed stimulus checked against a grant-timeline model
// plus a model of the two-register mux.
module tb_interconnect_scheduler;

    localparam int N  = 3;
    localparam int SW = 2;
    localparam int DW = 16;
`ifdef INTERCONNECT_SCHED_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic          clk;
    logic          resetn;
    logic [N-1:0]  req;
    logic [DW-1:0] dwell;
    logic          lock_s;
    logic [SW-1:0] sel;
    logic          clken;
    logic [N-1:0]  grant;
    logic          data_valid;
    logic          busy;

    int checks;
    int failures;
    int cyc;

    interconnect_scheduler #(
        .N_INPUTS    (N),
        .SEL_WIDTH   (SW),
        .DWELL_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .dwell      (dwell),
`ifdef INTERCONNECT_SCHED_LOCK_EN
        .lock       (lock_s),
`endif
        .sel        (sel),
        .clken      (clken),
        .grant      (grant),
        .data_valid (data_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mux model: sel_reg loads on clken, out follows sel_reg one cycle later.
    logic [7:0] in_vals [0:3];
    logic [1:0] mux_sel_reg;
    logic [7:0] mux_out;
    always @(posedge clk) begin
        mux_out <= in_vals[mux_sel_reg];
        if (clken === 1'b1) mux_sel_reg <= sel;
    end

    // Grant timeline model: pos counts cycles since the arbitration point
    // (1 = switch, 2 = settle, 3.. = dwell window).
    int m_active, m_k, m_pos, m_dw, m_last, m_sel;
    int e_sel;
    logic e_clken, e_dv, e_busy;
    logic [N-1:0] e_grant;

    logic [SW-1:0] obs_sel;
    logic obs_clken, obs_dv, obs_busy;
    logic [N-1:0] obs_grant;

    function automatic int pick_rr(input logic [N-1:0] r, input int last);
        for (int off = 1; off <= N; off++) begin
            int j;
            j = (last + off) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_k = 0; m_pos = 0; m_dw = 1; m_last = N - 1; m_sel = 0;
    endtask

    task automatic expect_outputs(input logic [N-1:0] r);
        if (m_active == 0) begin
            e_sel = m_sel; e_clken = 0; e_grant = '0; e_dv = 0; e_busy = 0;
        end else begin
            e_sel   = m_k;
            e_clken = (m_pos == 1);
            e_grant = N'(1) << m_k;
            e_busy  = 1;
            e_dv    = (m_pos >= 3) && r[m_k];
        end
    endtask

    task automatic model_step(input logic [N-1:0] r, input int dw, input logic lk,
                              input logic rst);
        int j;
        logic held;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_active == 0) begin
            j = pick_rr(r, m_last);
            if (j >= 0) begin m_active = 1; m_k = j; m_pos = 1; m_sel = j; end
        end else if (m_pos == 1) begin
            m_dw = (dw == 0) ? 1 : dw;
            m_last = m_k;
            m_pos = 2;
        end else if (m_pos == 2) begin
            m_pos = 3;
        end else begin
            held = LOCK_EN && lk && r[m_k];
            if (!r[m_k] || ((m_pos - 3 + 1) >= m_dw && !held)) begin
                j = pick_rr(r, m_last);
                if (j >= 0) begin m_k = j; m_pos = 1; m_sel = j; end
                else m_active = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    // One clock: drive inputs, compare mid-cycle, advance model at the edge.
    task automatic cycle(input logic [N-1:0] r, input int dw, input logic lk,
                         input logic rst, input bit chk);
        req = r; dwell = DW'(dw); lock_s = lk; resetn = ~rst;
        #4;
        obs_sel = sel; obs_clken = clken; obs_dv = data_valid;
        obs_busy = busy; obs_grant = grant;
        if (chk) begin
            expect_outputs(r);
            checks++;
            if (sel !== SW'(e_sel)) begin
                failures++; $display("FAIL sel cyc=%0d got=%0d exp=%0d", cyc, sel, e_sel);
            end
            checks++;
            if (clken !== e_clken) begin
                failures++; $display("FAIL clken cyc=%0d got=%b exp=%b", cyc, clken, e_clken);
            end
            checks++;
            if (grant !== e_grant) begin
                failures++; $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, grant, e_grant);
            end
            checks++;
            if (data_valid !== e_dv) begin
                failures++;
                $display("FAIL data_valid cyc=%0d got=%b exp=%b", cyc, data_valid, e_dv);
            end
            checks++;
            if (busy !== e_busy) begin
                failures++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy);
            end
            if (e_dv) begin
                checks++;
                if (mux_out !== in_vals[e_sel]) begin
                    failures++;
                    $display("FAIL mux_out cyc=%0d got=%h exp=%h", cyc, mux_out, in_vals[e_sel]);
                end
            end
        end
        @(posedge clk);
        model_step(r, dw, lk, rst);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        cycle('0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        cycle('0, 0, 1'b0, 1'b1, 1'b0);
        cycle('0, 0, 1'b0, 1'b1, 1'b0);
        model_reset();
        cycle('0, 0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_sel !== '0 || obs_clken !== 0 || obs_grant !== '0 || obs_dv !== 0 ||
            obs_busy !== 0) begin
            failures++;
            $display("FAIL reset_values got sel=%0d clken=%b grant=%b dv=%b busy=%b exp all 0",
                     obs_sel, obs_clken, obs_grant, obs_dv, obs_busy);
        end
    endtask

    task automatic test_single();
        logic [7:0] dv_hist;
        logic [7:0] clk_hist;
        logic [SW-1:0] sel1;
        for (int i = 0; i < 8; i++) begin
            cycle(3'b010, 4, 1'b0, 1'b0, 1'b1);
            dv_hist[i] = obs_dv; clk_hist[i] = obs_clken;
            if (i == 1) sel1 = obs_sel;
        end
        checks++;
        if (clk_hist[1] !== 1'b1 || sel1 !== 2'd1) begin
            failures++; $display("FAIL single_switch got clken=%b sel=%0d exp 1/1", clk_hist[1], sel1);
        end
        checks++;
        if (dv_hist !== 8'b0111_1000) begin
            failures++; $display("FAIL single_dv_window got=%b exp=01111000", dv_hist);
        end
        checks++;
        if (clk_hist[7] !== 1'b1) begin
            failures++; $display("FAIL single_regrant got=%b exp=1", clk_hist[7]);
        end
        for (int i = 0; i < 4; i++) cycle('0, 4, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_round_robin();
        int order [$];
        logic [15:0] dv_hist, dv_exp;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(3'b111, 2, 1'b0, 1'b0, 1'b1);
            dv_hist[i] = obs_dv;
            dv_exp[i] = (i >= 3) && (((i - 3) % 4) < 2);
            if (obs_clken === 1'b1) order.push_back(int'(obs_sel));
        end
        checks++;
        if (order.size() < 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 ||
            order[3] != 0) begin
            failures++; $display("FAIL rr_order got=%p exp='{0,1,2,0}", order);
        end
        checks++;
        if (dv_hist !== dv_exp) begin
            failures++; $display("FAIL rr_bursts got=%b exp=%b", dv_hist, dv_exp);
        end
    endtask

    task automatic test_dwell_zero();
        int run, max_run;
        run = 0; max_run = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(3'b111, 0, 1'b0, 1'b0, 1'b1);
            run = (obs_dv === 1'b1) ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        checks++;
        if (max_run != 1) begin
            failures++; $display("FAIL dwell_zero_run got=%0d exp=1", max_run);
        end
        for (int i = 0; i < 40; i++) cycle(N'($urandom_range(0, 7)), 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_early_release();
        logic [7:0] dv_hist, clk_hist;
        logic [SW-1:0] sel7;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle((i >= 6) ? 3'b100 : 3'b101, 10, 1'b0, 1'b0, 1'b1);
            dv_hist[i] = obs_dv; clk_hist[i] = obs_clken;
            if (i == 7) sel7 = obs_sel;
        end
        checks++;
        if (dv_hist[6:3] !== 4'b0111) begin
            failures++; $display("FAIL early_release_dv got=%b exp=0111", dv_hist[6:3]);
        end
        checks++;
        if (clk_hist[7] !== 1'b1 || sel7 !== 2'd2) begin
            failures++;
            $display("FAIL early_release_switch got clken=%b sel=%0d exp 1/2", clk_hist[7], sel7);
        end
        for (int i = 0; i < 6; i++) cycle('0, 10, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cycle(3'b010, 8, 1'b0, 1'b0, 1'b1);
        cycle(3'b010, 8, 1'b0, 1'b1, 1'b1);
        cycle(3'b111, 8, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_grant !== '0 || obs_dv !== 0 || obs_busy !== 0 || obs_clken !== 0) begin
            failures++;
            $display("FAIL reset_mid got grant=%b dv=%b busy=%b clken=%b exp all 0",
                     obs_grant, obs_dv, obs_busy, obs_clken);
        end
        cycle(3'b111, 8, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_clken !== 1'b1 || obs_sel !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_first got clken=%b sel=%0d exp 1/0", obs_clken, obs_sel);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        int dw;
        logic lk;
        r = 3'b001; dw = 3; lk = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) dw = $urandom_range(0, 5);
            if ($urandom_range(0, 5) == 0) lk = LOCK_EN && ($urandom_range(0, 1) == 1);
            cycle(r, dw, lk, ($urandom_range(0, 99) == 0), 1'b1);
        end
    endtask

`ifdef INTERCONNECT_SCHED_LOCK_EN
    task automatic test_lock();
        int run, dv_total;
        logic clk_after;
        do_reset();
        dv_total = 0;
        for (int i = 0; i < 23; i++) begin
            cycle(3'b010, 2, (i < 22), 1'b0, 1'b1);
            if (obs_dv === 1'b1) dv_total++;
        end
        clk_after = obs_clken;
        checks++;
        if (dv_total != 20) begin
            failures++; $display("FAIL lock_run got=%0d exp=20", dv_total);
        end
        cycle(3'b010, 2, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_clken !== 1'b1 || clk_after !== 1'b0) begin
            failures++;
            $display("FAIL lock_exit got clken=%b prev=%b exp 1/0", obs_clken, clk_after);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; failures = 0; cyc = 0;
        for (int i = 0; i < 4; i++) in_vals[i] = 8'($urandom);
        mux_sel_reg = '0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_dwell_zero();
        test_early_release();
        test_reset_mid();
`ifdef INTERCONNECT_SCHED_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interconnect_scheduler.md
# interconnect_scheduler

Round-robin scheduler that shares the `simple_interconnect` N-to-1 mux among `N_INPUTS` requesters. It arbitrates requests, drives the mux `sel`/`clken` pins, accounts for the mux's two-register pipeline, and holds each grant for a programmable dwell time. It flags when the mux output carries the granted channel's data. It sits beside the mux, between the per-channel request logic and the downstream consumer of `out`.

## Interface

Parameters:
- `N_INPUTS`, 3: number of requesters and mux inputs; at least 2.
- `SEL_WIDTH`, 2: mux select width; must satisfy 2^SEL_WIDTH ≥ N_INPUTS.
- `DWELL_WIDTH`, 16: width of the dwell length and dwell counter.

Ports:
- `clk`  in  1  single clock, shared with the mux.
- `resetn`  in  1  reset, synchronous and active-low.
- `req`  in  N_INPUTS  per-channel request, level-sensitive.
- `dwell`  in  DWELL_WIDTH  grant length in valid cycles; 0 is treated as 1.
- `sel`  out  SEL_WIDTH  to mux `sel`.
- `clken`  out  1  to mux `clken`; single-cycle load strobe.
- `grant`  out  N_INPUTS  one-hot grant; all zero when idle.
- `data_valid`  out  1  mux `out` currently carries the granted channel.
- `busy`  out  1  high in every state except IDLE.

## Operation

- The arbiter is round-robin. The search starts at `last+1` modulo N_INPUTS, where `last` is the most recently granted index. After reset, `last` = N_INPUTS-1, so input 0 wins first.
- States:
  - IDLE: if any `req` is set, pick winner k and go to SWITCH; otherwise stay.
  - SWITCH (1 cycle): `sel`=k, `clken`=1, `grant`=onehot(k); latch `dwell` (0→1) into the counter; `last`←k; go to SETTLE.
  - SETTLE (1 cycle): `clken`=0, `grant` held; go to DWELL.
  - DWELL: `data_valid`=1 while `req[k]`=1; the counter decrements each cycle.
    - Exit when the counter reaches 1, or in the first cycle `req[k]`=0.
    - In the exit cycle, `data_valid`=`req[k]`.
    - On exit, arbitrate the same cycle, excluding nothing: go to SWITCH if any `req` is set, else IDLE.
- A sole requester is re-granted through SWITCH/SETTLE. This leaves a 2-cycle `data_valid` gap per dwell period.
- `req` bits at indices ≥ N_INPUTS do not exist. `sel` never exceeds N_INPUTS-1.
- `sel` holds its last value outside SWITCH. `clken` is high only in SWITCH.
- A request arriving during SWITCH or SETTLE waits for the next arbitration point.
- A request drop during SWITCH or SETTLE is not observed until DWELL. DWELL then exits in its first cycle, with `data_valid`=0.

## Timing

- Reset values: `sel`=0, `clken`=0, `grant`=0, `data_valid`=0, `busy`=0, state IDLE, counter 0, `last`=N_INPUTS-1.
- Latency from `req` rising in cycle T while IDLE:
  - SWITCH in T+1.
  - SETTLE in T+2, while the mux loads `sel_reg` and then `out`.
  - `data_valid`=1 in T+3, aligned with `out` showing `in[k]`.
- Grant length: `data_valid` is high for exactly max(`dwell`,1) cycles if `req[k]` stays high.
- Back-to-back grants: the last DWELL cycle is followed by SWITCH, then SETTLE, then the new DWELL.
- Reset asserted mid-operation: all outputs take reset values at the next edge. The mux keeps its `sel_reg` because `clken`=0. The first post-reset SWITCH reloads it.
- Counter arithmetic is unsigned DWELL_WIDTH bits; the counter never wraps below 1 inside DWELL.

## Configuration

- `INTERCONNECT_SCHED_LOCK_EN`:
  - When defined, adds input `lock` (1 bit).
  - While in DWELL with `lock`=1 and `req[k]`=1, dwell expiry is ignored and the counter holds at 1. The grant persists until `lock` falls or `req[k]` drops.
  - When `lock` falls with the counter at 1, DWELL exits that cycle.
- Without the macro, the port is absent and every grant is bounded by `dwell`.

## Structure

- Package `interconnect_sched_pkg` holds:
  - the state enum typedef (IDLE, SWITCH, SETTLE, DWELL);
  - the constant `MUX_LATENCY`=2, which fixes SETTLE to MUX_LATENCY-1 cycles.
- Sub-module `rr_pick`: combinational next-winner search. Inputs are `req` and `last`; outputs are `any` and `idx`. It is reused at IDLE and DWELL exit.

## Test plan

- Single request, N=3, `dwell`=4, `req`=3'b010 at T → `clken` high at T+1 with `sel`=1; `data_valid` high T+3..T+6; then `clken` again at T+7.
- All requesting, `dwell`=2 → grant order 0,1,2,0; each `data_valid` burst is 2 cycles; gaps are 2 cycles; the bench-model mux `out` equals `in[sel]` whenever `data_valid`=1.
- `dwell`=0 → treated as 1: one `data_valid` cycle per grant.
- Early release: `dwell`=10, `req[0]` drops 3 cycles into DWELL, `req[2]` pending → `data_valid` 0 in the drop cycle; SWITCH to `sel`=2 next cycle.
- Reset mid-DWELL → `grant`, `data_valid`, `busy`, `clken` all 0 after the edge; first grant after release goes to input 0.
- With `INTERCONNECT_SCHED_LOCK_EN`, `dwell`=2, `lock`=1 for 20 cycles, `req[1]` high → 20 consecutive `data_valid` cycles; exit in the cycle `lock` falls.
